// File: rtl/demux_deser.sv
// Serial-to-parallel receiver: steers LSB-first serial bits into a WIDTH-bit word and
// hands completed words to the consumer through a one-entry valid/ready buffer.
module demux_deser #(
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    output logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             overrun
);

    // Handshake: a word on q transfers on any rising edge where q_valid=1 and q_ready=1;
    // q_ready has no effect while q_valid=0, and q holds its value after being consumed.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    buf_state_e       r_state;
    buf_state_e       w_state_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_q;
    logic             r_overrun;

    logic             w_capture;
    logic             w_last;
    logic [WIDTH-1:0] w_word;
    logic             w_load;
    logic             w_drop;

    assign w_capture = en && !clr;
    assign w_last    = w_capture && (r_sel == SEL_W'(WIDTH - 1));
    // The final bit bypasses the shift register so the word is ready on the same edge.
    assign w_word    = {din, r_shreg[WIDTH-2:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            BUF_EMPTY: begin
                if (w_last) begin
                    w_state_nxt = BUF_FULL;
                    w_load      = 1'b1;
                end
            end
            BUF_FULL: begin
                if (w_last) begin
                    if (q_ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else if (q_ready) begin
                    w_state_nxt = BUF_EMPTY;
                end
            end
            default: w_state_nxt = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel   <= '0;
            r_shreg <= '0;
        end else if (clr) begin
            r_sel   <= '0;
            r_shreg <= '0;
        end else if (en) begin
            r_shreg[r_sel] <= din;
            if (w_last) begin
                r_sel <= '0;
            end else begin
                r_sel <= r_sel + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q       <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_q <= w_word;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign sel     = r_sel;
    assign q       = r_q;
    assign q_valid = (r_state == BUF_FULL);
    assign overrun = r_overrun;

endmodule

// File: tb/tb_demux_deser.sv
// Directed bench for demux_deser: hand-computed words, buffer handshake, clr and reset cases.
module tb_demux_deser;

    localparam int WIDTH = 8;
    localparam int SEL_W = 3;

    logic             clk;
    logic             reset;
    logic             en;
    logic             din;
    logic             clr;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_ready;
    logic             overrun;

    int pass_cnt;
    int total_cnt;

    demux_deser #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .din     (din),
        .clr     (clr),
        .sel     (sel),
        .q       (q),
        .q_valid (q_valid),
        .q_ready (q_ready),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en    = 1'b0;
        clr   = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) begin
            en  = 1'b1;
            din = w[i];
            tick();
        end
        en  = 1'b0;
        din = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b0;
        en        = 1'b0;
        din       = 1'b0;
        clr       = 1'b0;
        q_ready   = 1'b0;
        #1;

        // Reset state
        do_reset();
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_q", 32'(q), 32'h0);
        check("rst_q_valid", 32'(q_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

        // q_ready while empty does nothing
        q_ready = 1'b1;
        tick();
        check("empty_ready_valid", 32'(q_valid), 32'h0);
        q_ready = 1'b0;

        // Word 0x4D with no consumer
        send_word(8'h4D);
        check("t1_q", 32'(q), 32'h4D);
        check("t1_q_valid", 32'(q_valid), 32'h1);
        check("t1_sel", 32'(sel), 32'h0);
        check("t1_overrun", 32'(overrun), 32'h0);

        // Second word dropped while full
        send_word(8'hA5);
        check("t2_q_held", 32'(q), 32'h4D);
        check("t2_q_valid", 32'(q_valid), 32'h1);
        check("t2_overrun", 32'(overrun), 32'h1);
        q_ready = 1'b1;
        tick();
        q_ready = 1'b0;
        check("t2_consumed_valid", 32'(q_valid), 32'h0);
        check("t2_consumed_q", 32'(q), 32'h4D);
        check("t2_overrun_sticky", 32'(overrun), 32'h1);

        // Continuous stream with the consumer always ready
        do_reset();
        q_ready = 1'b1;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            logic [2*WIDTH-1:0] stream;
            stream = 16'hC33C;
            en  = 1'b1;
            din = stream[i];
            tick();
            if (i == WIDTH - 1) begin
                check("t3_first_q", 32'(q), 32'h3C);
                check("t3_first_valid", 32'(q_valid), 32'h1);
            end
            if (i == WIDTH) begin
                check("t3_consumed_valid", 32'(q_valid), 32'h0);
                check("t3_consumed_q", 32'(q), 32'h3C);
            end
        end
        en = 1'b0;
        check("t3_second_q", 32'(q), 32'hC3);
        check("t3_second_valid", 32'(q_valid), 32'h1);
        check("t3_overrun", 32'(overrun), 32'h0);
        q_ready = 1'b0;

        // Simultaneous consume and fill keeps the buffer full with no overrun
        do_reset();
        send_word(8'h3C);
        for (int i = 0; i < WIDTH; i++) begin
            logic [WIDTH-1:0] w;
            w       = 8'h96;
            en      = 1'b1;
            din     = w[i];
            q_ready = (i == WIDTH - 1);
            tick();
        end
        en      = 1'b0;
        q_ready = 1'b0;
        check("t3b_q", 32'(q), 32'h96);
        check("t3b_valid", 32'(q_valid), 32'h1);
        check("t3b_overrun", 32'(overrun), 32'h0);

        // Five stale bits, then clr with a bit in the same cycle
        do_reset();
        for (int i = 0; i < 5; i++) begin
            en  = 1'b1;
            din = 1'b0;
            tick();
        end
        check("t4_sel_partial", 32'(sel), 32'h5);
        clr = 1'b1;
        en  = 1'b1;
        din = 1'b0;
        tick();
        clr = 1'b0;
        en  = 1'b0;
        check("t4_sel_after_clr", 32'(sel), 32'h0);
        check("t4_valid_after_clr", 32'(q_valid), 32'h0);
        send_word(8'hFF);
        check("t4_q", 32'(q), 32'hFF);
        check("t4_valid", 32'(q_valid), 32'h1);

        // Word 0x81 with idle cycles between strobes
        do_reset();
        for (int i = 0; i < WIDTH; i++) begin
            logic [WIDTH-1:0] w;
            w   = 8'h81;
            en  = 1'b1;
            din = w[i];
            tick();
            if (i < WIDTH - 1) begin
                en  = 1'b0;
                din = ~w[i];
                tick();
                check("t5_sel_hold", 32'(sel), 32'(i + 1));
            end
        end
        en = 1'b0;
        check("t5_q", 32'(q), 32'h81);
        check("t5_valid", 32'(q_valid), 32'h1);

        // Reset mid-word with a pending word and overrun set
        do_reset();
        send_word(8'h55);
        send_word(8'h11);
        check("t6_overrun_set", 32'(overrun), 32'h1);
        check("t6_q_pending", 32'(q), 32'h55);
        for (int i = 0; i < 4; i++) begin
            en  = 1'b1;
            din = 1'b1;
            tick();
        end
        check("t6_sel_partial", 32'(sel), 32'h4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        en    = 1'b0;
        check("t6_rst_sel", 32'(sel), 32'h0);
        check("t6_rst_q", 32'(q), 32'h0);
        check("t6_rst_valid", 32'(q_valid), 32'h0);
        check("t6_rst_overrun", 32'(overrun), 32'h0);
        send_word(8'h0F);
        check("t6_q", 32'(q), 32'h0F);
        check("t6_valid", 32'(q_valid), 32'h1);
        check("t6_overrun", 32'(overrun), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
